// File: rtl/bf_loop_ctrl_if.sv
// rtl/bf_loop_ctrl_if.sv - core/program-port bundle for the bf loop sequencer (loop_count only with BF_LOOP_STATS_EN)
interface bf_loop_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
);
    localparam int SP_W = $clog2(DEPTH) + 1;

    // Jump request from the core
    logic              req;
    logic              op;
    logic [ADDR_W-1:0] pc;
    logic              data_zero;

    // Jump result back to the core
    logic              done;
    logic [ADDR_W-1:0] next_pc;
    logic              busy;

    // Borrowed program read port
    logic              scan_ren;
    logic [ADDR_W-1:0] scan_addr;
    logic [7:0]        prog_rval;

    // Status
    logic              err;
    logic [1:0]        err_code;
    logic [SP_W-1:0]   sp;
`ifdef BF_LOOP_STATS_EN
    logic [15:0]       loop_count;
`endif

    modport master (
        output req, op, pc, data_zero, prog_rval,
        input  done, next_pc, busy, scan_ren, scan_addr, err, err_code, sp
`ifdef BF_LOOP_STATS_EN
        , input loop_count
`endif
    );

    modport slave (
        input  req, op, pc, data_zero, prog_rval,
        output done, next_pc, busy, scan_ren, scan_addr, err, err_code, sp
`ifdef BF_LOOP_STATS_EN
        , output loop_count
`endif
    );
endinterface

// File: rtl/bf_loop_ctrl.sv
// rtl/bf_loop_ctrl.sv - bf '['/']' loop sequencer with return stack and forward scan (optional BF_LOOP_STATS_EN)
module bf_loop_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int NEST_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    bf_loop_ctrl_if.slave bus
);
    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SCAN_RD  = 2'd1;
    localparam logic [1:0] S_SCAN_CHK = 2'd2;
    localparam logic [1:0] S_ERROR    = 2'd3;

    localparam logic [7:0] CH_OPEN  = 8'h5B;
    localparam logic [7:0] CH_CLOSE = 8'h5D;

    localparam logic [1:0] E_OVERFLOW  = 2'b01;
    localparam logic [1:0] E_UNDERFLOW = 2'b10;
    localparam logic [1:0] E_UNMATCHED = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              scan_ren_q, scan_ren_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [NEST_W-1:0] depth_q, depth_d;
`ifdef BF_LOOP_STATS_EN
    logic [15:0]       loop_count_q, loop_count_d;
`endif

    logic [SP_W-1:0]   sp_m1;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;

    assign sp_m1    = sp_q - SP_W'(1);
    assign push_idx = sp_q[IDX_W-1:0];
    assign top_idx  = sp_m1[IDX_W-1:0];

    // Next-state logic: request decode in IDLE, one character per SCAN_RD/SCAN_CHK pair
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        stack_d     = stack_q;
        next_pc_d   = next_pc_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        scan_ren_d  = 1'b0;
        scan_addr_d = scan_addr_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        depth_d     = depth_q;
`ifdef BF_LOOP_STATS_EN
        loop_count_d = loop_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (!bus.op) begin
                        if (bus.data_zero) begin
                            // Loop skipped: hunt for the matching ']' in program memory
                            depth_d     = NEST_W'(1);
                            scan_addr_d = bus.pc + ADDR_W'(1);
                            scan_ren_d  = 1'b1;
                            busy_d      = 1'b1;
                            state_d     = S_SCAN_RD;
                        end else if (sp_q == SP_W'(DEPTH)) begin
                            err_d      = 1'b1;
                            err_code_d = E_OVERFLOW;
                            busy_d     = 1'b1;
                            state_d    = S_ERROR;
                        end else begin
                            stack_d[push_idx] = bus.pc;
                            sp_d              = sp_q + SP_W'(1);
                            next_pc_d         = bus.pc + ADDR_W'(1);
                            done_d            = 1'b1;
                        end
                    end else begin
                        if (sp_q == '0) begin
                            err_d      = 1'b1;
                            err_code_d = E_UNDERFLOW;
                            busy_d     = 1'b1;
                            state_d    = S_ERROR;
                        end else if (!bus.data_zero) begin
                            // Taken back-jump: resume just after the open '['
                            next_pc_d = stack_q[top_idx] + ADDR_W'(1);
                            done_d    = 1'b1;
`ifdef BF_LOOP_STATS_EN
                            if (loop_count_q != 16'hFFFF) begin
                                loop_count_d = loop_count_q + 16'd1;
                            end
`endif
                        end else begin
                            sp_d      = sp_m1;
                            next_pc_d = bus.pc + ADDR_W'(1);
                            done_d    = 1'b1;
                        end
                    end
                end
            end
            S_SCAN_RD: begin
                state_d = S_SCAN_CHK;
            end
            S_SCAN_CHK: begin
                if (bus.prog_rval == CH_CLOSE && depth_q == NEST_W'(1)) begin
                    next_pc_d = scan_addr_q + ADDR_W'(1);
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (bus.prog_rval == 8'h00 ||
                             (bus.prog_rval == CH_OPEN && depth_q == '1) ||
                             scan_addr_q == '1) begin
                    // End of program, nesting overflow, or top of memory: no wrap-around
                    err_d      = 1'b1;
                    err_code_d = E_UNMATCHED;
                    state_d    = S_ERROR;
                end else begin
                    if (bus.prog_rval == CH_OPEN) begin
                        depth_d = depth_q + NEST_W'(1);
                    end else if (bus.prog_rval == CH_CLOSE) begin
                        depth_d = depth_q - NEST_W'(1);
                    end
                    scan_addr_d = scan_addr_q + ADDR_W'(1);
                    scan_ren_d  = 1'b1;
                    state_d     = S_SCAN_RD;
                end
            end
            default: begin
                // ERROR is terminal until reset; everything holds
                state_d = S_ERROR;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sp_q        <= '0;
            stack_q     <= '{default: '0};
            next_pc_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            scan_ren_q  <= 1'b0;
            scan_addr_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            depth_q     <= '0;
`ifdef BF_LOOP_STATS_EN
            loop_count_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            stack_q     <= stack_d;
            next_pc_q   <= next_pc_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            scan_ren_q  <= scan_ren_d;
            scan_addr_q <= scan_addr_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            depth_q     <= depth_d;
`ifdef BF_LOOP_STATS_EN
            loop_count_q <= loop_count_d;
`endif
        end
    end

    assign bus.done      = done_q;
    assign bus.next_pc   = next_pc_q;
    assign bus.busy      = busy_q;
    assign bus.scan_ren  = scan_ren_q;
    assign bus.scan_addr = scan_addr_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.sp        = sp_q;
`ifdef BF_LOOP_STATS_EN
    assign bus.loop_count = loop_count_q;
`endif
endmodule

// File: tb/tb_bf_loop_ctrl.sv
// tb/tb_bf_loop_ctrl.sv - scoreboard bench for bf_loop_ctrl
module tb_bf_loop_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bf_loop_ctrl_if #(.ADDR_W(8), .DEPTH(16)) bus ();

    bf_loop_ctrl #(.ADDR_W(8), .DEPTH(16), .NEST_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Program memory, synchronous read: data valid the cycle after scan_ren
    logic [7:0] mem [256];
    always @(posedge clk) if (bus.scan_ren) bus.prog_rval <= mem[bus.scan_addr];

    typedef struct {
        logic [7:0] next_pc;
        logic [4:0] sp;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   scan_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one request, expect done; lat = cycles from the req cycle to the done cycle
    task automatic issue(input string tag, input logic o, input logic [7:0] p, input logic dz,
                         input logic [7:0] exp_pc, input logic [4:0] exp_sp, input int exp_lat);
        exp_t       e;
        int         lat;
        logic [7:0] exp_addr;
        e.next_pc = exp_pc;
        e.sp      = exp_sp;
        e.lat     = exp_lat;
        sb.push_back(e);
        bus.req = 1'b1; bus.op = o; bus.pc = p; bus.data_zero = dz;
        @(negedge clk);
        bus.req  = 1'b0;
        lat      = 1;
        exp_addr = p + 8'd1;
        while (!bus.done && lat < 600) begin
            if (bus.scan_ren) begin
                chk({tag, "_addr"}, bus.scan_addr, exp_addr);
                exp_addr++;
                scan_seen++;
            end
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_pc"},   bus.next_pc, e.next_pc);
        chk({tag, "_sp"},   bus.sp, e.sp);
        chk({tag, "_lat"},  lat, e.lat);
    endtask

    // Drive one request that must end in ERROR without a done pulse
    task automatic issue_err(input string tag, input logic o, input logic [7:0] p, input logic dz,
                             input logic [1:0] exp_code, input int limit);
        int   lat;
        logic seen_done;
        bus.req = 1'b1; bus.op = o; bus.pc = p; bus.data_zero = dz;
        @(negedge clk);
        bus.req   = 1'b0;
        lat       = 1;
        seen_done = 1'b0;
        while (!bus.err && lat < limit) begin
            if (bus.done) seen_done = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_err"},    bus.err, 1);
        chk({tag, "_code"},   bus.err_code, exp_code);
        chk({tag, "_busy"},   bus.busy, 1);
        chk({tag, "_nodone"}, seen_done | bus.done, 0);
    endtask

    initial begin
        bus.req = 1'b0; bus.op = 1'b0; bus.pc = 8'h00; bus.data_zero = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h2B;
        // "[+[-]>]." at 0x00
        mem[8'h00] = 8'h5B; mem[8'h01] = 8'h2B; mem[8'h02] = 8'h5B; mem[8'h03] = 8'h2D;
        mem[8'h04] = 8'h5D; mem[8'h05] = 8'h3E; mem[8'h06] = 8'h5D; mem[8'h07] = 8'h2E;
        // "[+\0]" at 0x40
        mem[8'h40] = 8'h5B; mem[8'h41] = 8'h2B; mem[8'h42] = 8'h00; mem[8'h43] = 8'h5D;
        // long loop body at 0x80 for the mid-scan reset
        mem[8'h80] = 8'h5B; mem[8'h8F] = 8'h5D;
        // "[[]]" at 0xA0
        mem[8'hA0] = 8'h5B; mem[8'hA1] = 8'h5B; mem[8'hA2] = 8'h5D; mem[8'hA3] = 8'h5D;

        do_reset();
        chk("rst_done",     bus.done, 0);
        chk("rst_next_pc",  bus.next_pc, 0);
        chk("rst_busy",     bus.busy, 0);
        chk("rst_err",      bus.err, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_sp",       bus.sp, 0);
        chk("rst_scan_ren", bus.scan_ren, 0);

        issue("push10",  1'b0, 8'h10, 1'b0, 8'h11, 5'd1, 1);
        issue("back20",  1'b1, 8'h20, 1'b0, 8'h11, 5'd1, 1);
        issue("exit20",  1'b1, 8'h20, 1'b1, 8'h21, 5'd0, 1);

        // Skip scan, match 6 characters ahead: SCAN_RD entry + 2 cycles per character
        scan_seen = 0;
        issue("scan00",  1'b0, 8'h00, 1'b1, 8'h07, 5'd0, 13);
        chk("scan00_nscan", scan_seen, 6);
        issue("nestA0",  1'b0, 8'hA0, 1'b1, 8'hA4, 5'd0, 7);

        // PC wrap
        issue("pushFF",  1'b0, 8'hFF, 1'b0, 8'h00, 5'd1, 1);
        issue("back30",  1'b1, 8'h30, 1'b0, 8'h00, 5'd1, 1);
        issue("exit30",  1'b1, 8'h30, 1'b1, 8'h31, 5'd0, 1);

        // Reset during a scan aborts it
        bus.req = 1'b1; bus.op = 1'b0; bus.pc = 8'h80; bus.data_zero = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        chk("midscan_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",     bus.busy, 0);
        chk("abort_scan_ren", bus.scan_ren, 0);
        chk("abort_done",     bus.done, 0);
        reset = 1'b0;
        issue("push50",  1'b0, 8'h50, 1'b0, 8'h51, 5'd1, 1);
        for (int i = 0; i < 3; i++) issue("back60", 1'b1, 8'h60, 1'b0, 8'h51, 5'd1, 1);
`ifdef BF_LOOP_STATS_EN
        chk("loop_count", bus.loop_count, 3);
`endif
        issue("exit60",  1'b1, 8'h60, 1'b1, 8'h61, 5'd0, 1);

        // Fill the stack, then overflow
        for (int i = 0; i < 16; i++) issue("fill", 1'b0, 8'(i), 1'b0, 8'(i + 1), 5'(i + 1), 1);
        issue_err("ovf", 1'b0, 8'h10, 1'b0, 2'b01, 10);
        // Requests in ERROR are ignored and the stack is frozen
        bus.req = 1'b1; bus.op = 1'b1; bus.pc = 8'h33; bus.data_zero = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("ovf_hold_code", bus.err_code, 2'b01);
        chk("ovf_hold_sp",   bus.sp, 16);
        chk("ovf_hold_done", bus.done, 0);
        do_reset();
        chk("ovf_rst_err",  bus.err, 0);
        chk("ovf_rst_sp",   bus.sp, 0);
        chk("ovf_rst_busy", bus.busy, 0);

        issue_err("unf",  1'b1, 8'h20, 1'b0, 2'b10, 10);
        do_reset();
        issue_err("nul40", 1'b0, 8'h40, 1'b1, 2'b11, 20);
        do_reset();
        issue_err("endF0", 1'b0, 8'hF0, 1'b1, 2'b11, 100);
        do_reset();
        mem[8'hFF] = 8'h5D;
        issue("matchFF", 1'b0, 8'hFE, 1'b1, 8'h00, 5'd0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
